// File: rtl/can_frame_sequencer_pkg.sv
// Shared types and constants for the CAN transmit frame sequencer.
package can_pkg;

   localparam int          CAN_ID_W       = 11;
   localparam int          CAN_MAX_BYTES  = 8;
   localparam int          CAN_CRC_W      = 15;
   localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

   typedef enum logic [2:0] {
      IDLE,
      ID,
      DATA,
      CRC,
      DONE
   } can_seq_state_t;

   function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc, input logic [3:0] max_bytes);
      return (dlc > max_bytes) ? max_bytes : dlc;
   endfunction

endpackage

// File: rtl/can_frame_sequencer_if.sv
// Frame request handshake between a frame producer and the sequencer.
interface can_frame_sequencer_if import can_pkg::*; #(
   parameter int ID_W = CAN_ID_W
);
   logic            req_valid;
   logic            req_ready;
   logic [ID_W-1:0] req_id;
   logic [3:0]      req_dlc;
   logic [63:0]     req_data;

   modport master (output req_valid, req_id, req_dlc, req_data, input req_ready);
   modport slave  (input req_valid, req_id, req_dlc, req_data, output req_ready);
endinterface

// File: rtl/can_frame_sequencer_crc15.sv
// Serial CAN CRC register; a clear together with an enable restarts from zero and absorbs that bit.
module can_crc15 import can_pkg::*; #(
   parameter int             CRC_W    = CAN_CRC_W,
   parameter logic [CRC_W-1:0] CRC_POLY = CAN_CRC15_POLY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] base;
   logic [CRC_W-1:0] step;

   always_comb begin
      base = clr ? '0 : crc;
      step = {base[CRC_W-2:0], 1'b0} ^ ((bit_in ^ base[CRC_W-1]) ? CRC_POLY : '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         crc <= '0;
      end else if (en) begin
         crc <= step;
      end else if (clr) begin
         crc <= '0;
      end
   end

endmodule

// File: rtl/can_frame_sequencer.sv
// CAN transmit sequencer: serialises ID, data and CRC-15 one bit per clock with field strobes.
// Optional bit stuffing is enabled by defining CAN_BIT_STUFF_EN.
module can_frame_sequencer import can_pkg::*; #(
   parameter int               ID_W      = CAN_ID_W,
   parameter int               MAX_BYTES = CAN_MAX_BYTES,
   parameter int               CRC_W     = CAN_CRC_W,
   parameter logic [CRC_W-1:0] CRC_POLY  = CAN_CRC15_POLY
) (
   input  logic                 clk,
   input  logic                 rst,
   can_frame_sequencer_if.slave req,
   output logic                 bit_out,
   output logic                 bit_valid,
   output logic                 id_en,
   output logic                 data_en,
   output logic                 crc_en,
   output logic                 stuff_flag,
   output logic                 busy,
   output logic                 done,
   output logic [CRC_W-1:0]     crc_out
);

   can_seq_state_t   state, state_nxt;
   logic [6:0]       cnt, cnt_nxt;
   logic [ID_W-1:0]  id_sh, id_sh_nxt;
   logic [63:0]      data_sh, data_sh_nxt;
   logic [CRC_W-1:0] crc_sh, crc_sh_nxt;
   logic [3:0]       dlc_q, dlc_nxt;
   logic [CRC_W-1:0] crc_out_nxt;
   logic [CRC_W-1:0] crc;
   logic             ready_q;
   logic             bit_nxt, bit_valid_nxt, id_en_nxt, data_en_nxt, crc_en_nxt, stuff_nxt;
   logic             crc_clr, enter_crc, stuff_due;

   assign req.req_ready = ready_q;

   can_crc15 #(
      .CRC_W   (CRC_W),
      .CRC_POLY(CRC_POLY)
   ) u_crc (
      .clk   (clk),
      .rst   (rst),
      .clr   (crc_clr),
      .en    (id_en_nxt | data_en_nxt),
      .bit_in(bit_nxt),
      .crc   (crc)
   );

   // Everything below computes what the next cycle presents; the register block then latches it.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      id_sh_nxt   = id_sh;
      data_sh_nxt = data_sh;
      crc_sh_nxt  = crc_sh;
      dlc_nxt     = dlc_q;
      crc_out_nxt = crc_out;
      bit_nxt     = 1'b0;
      id_en_nxt   = 1'b0;
      data_en_nxt = 1'b0;
      crc_en_nxt  = 1'b0;
      stuff_nxt   = 1'b0;
      crc_clr     = 1'b0;
      enter_crc   = 1'b0;
      if (stuff_due) begin
         bit_nxt   = ~bit_out;
         stuff_nxt = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (req.req_valid) begin
                  state_nxt   = ID;
                  dlc_nxt     = clamp_dlc(req.req_dlc, 4'(MAX_BYTES));
                  data_sh_nxt = req.req_data;
                  bit_nxt     = req.req_id[ID_W-1];
                  id_sh_nxt   = req.req_id << 1;
                  id_en_nxt   = 1'b1;
                  cnt_nxt     = 7'd1;
                  crc_clr     = 1'b1;
               end
            end
            ID: begin
               if (cnt == 7'(ID_W)) begin
                  if (dlc_q == 4'd0) begin
                     enter_crc = 1'b1;
                  end else begin
                     state_nxt   = DATA;
                     bit_nxt     = data_sh[63];
                     data_sh_nxt = data_sh << 1;
                     data_en_nxt = 1'b1;
                     cnt_nxt     = 7'd1;
                  end
               end else begin
                  bit_nxt   = id_sh[ID_W-1];
                  id_sh_nxt = id_sh << 1;
                  id_en_nxt = 1'b1;
                  cnt_nxt   = cnt + 7'd1;
               end
            end
            DATA: begin
               if (cnt == {dlc_q, 3'b000}) begin
                  enter_crc = 1'b1;
               end else begin
                  bit_nxt     = data_sh[63];
                  data_sh_nxt = data_sh << 1;
                  data_en_nxt = 1'b1;
                  cnt_nxt     = cnt + 7'd1;
               end
            end
            CRC: begin
               if (cnt == 7'(CRC_W)) begin
                  state_nxt = DONE;
               end else begin
                  bit_nxt    = crc_sh[CRC_W-1];
                  crc_sh_nxt = crc_sh << 1;
                  crc_en_nxt = 1'b1;
                  cnt_nxt    = cnt + 7'd1;
               end
            end
            DONE: begin
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
         // The CRC register already holds the last data bit, so its value is final here.
         if (enter_crc) begin
            state_nxt   = CRC;
            bit_nxt     = crc[CRC_W-1];
            crc_sh_nxt  = crc << 1;
            crc_out_nxt = crc;
            crc_en_nxt  = 1'b1;
            cnt_nxt     = 7'd1;
         end
      end
      bit_valid_nxt = id_en_nxt | data_en_nxt | crc_en_nxt | stuff_nxt;
   end

`ifdef CAN_BIT_STUFF_EN
   logic [2:0] run_len, run_len_nxt;

   // Runs span field boundaries; nothing is stuffed after the final CRC bit.
   always_comb begin
      stuff_due = (state == ID || state == DATA || state == CRC) && (run_len == 3'd5) &&
                  !(state == CRC && cnt == 7'(CRC_W));
      if (!bit_valid_nxt) begin
         run_len_nxt = 3'd0;
      end else if (bit_valid && (bit_nxt == bit_out)) begin
         run_len_nxt = run_len + 3'd1;
      end else begin
         run_len_nxt = 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_len <= 3'd0;
      end else begin
         run_len <= run_len_nxt;
      end
   end
`else
   assign stuff_due = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         id_sh      <= '0;
         data_sh    <= '0;
         crc_sh     <= '0;
         dlc_q      <= '0;
         crc_out    <= '0;
         bit_out    <= 1'b0;
         bit_valid  <= 1'b0;
         id_en      <= 1'b0;
         data_en    <= 1'b0;
         crc_en     <= 1'b0;
         stuff_flag <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         id_sh      <= id_sh_nxt;
         data_sh    <= data_sh_nxt;
         crc_sh     <= crc_sh_nxt;
         dlc_q      <= dlc_nxt;
         crc_out    <= crc_out_nxt;
         bit_out    <= bit_nxt;
         bit_valid  <= bit_valid_nxt;
         id_en      <= id_en_nxt;
         data_en    <= data_en_nxt;
         crc_en     <= crc_en_nxt;
         stuff_flag <= stuff_nxt;
         busy       <= (state_nxt != IDLE);
         done       <= (state_nxt == DONE);
         ready_q    <= (state_nxt == IDLE);
      end
   end

endmodule

// File: doc/can_frame_sequencer.md
Name: can_frame_sequencer

Overview:
Transmit-side sequencer for the CAN packet path. It accepts one frame request (ID, DLC, up to 8 data bytes) through a valid/ready handshake. It then emits the frame MSB-first, one bit per clock, on bit_out. It drives the id_en/data_en field strobes that the CAN controller deserializer consumes, and appends a serial CRC-15 field computed over the ID and data bits.

Parameters:
ID_W, 11, identifier width in bits
MAX_BYTES, 8, maximum data bytes per frame; DLC is clamped to this value
CRC_W, 15, CRC field width
CRC_POLY, 15'h4599, CAN CRC-15 generator polynomial

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  reset; asynchronous, active-low
req_valid  in  1  frame request present
req_ready  out  1  high only in IDLE; accept = req_valid && req_ready at posedge
req_id  in  ID_W  identifier, sent MSB first
req_dlc  in  4  data byte count
req_data  in  64  byte0 in [63:56], byte1 in [55:48], and so on; each byte sent MSB first
bit_out  out  1  serial bit
bit_valid  out  1  bit_out carries a frame bit (field or stuff)
id_en  out  1  bit_out is an ID bit
data_en  out  1  bit_out is a data bit
crc_en  out  1  bit_out is a CRC bit
stuff_flag  out  1  bit_out is a stuff bit (STUFF_EN only; otherwise tied 0)
busy  out  1  a frame is in progress (state not IDLE)
done  out  1  one-cycle pulse after the last CRC bit
crc_out  out  CRC_W  final CRC; valid from CRC entry until the next accept

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE. All outputs are 0 except req_ready=1. The CRC register, counters and crc_out are cleared.
- FSM states: IDLE, ID, DATA, CRC, DONE.
- IDLE: on accept, register req_id, min(req_dlc, MAX_BYTES) and req_data, clear the CRC, then go to ID. req_* changes after accept are ignored.
- ID: ID_W cycles; bit_valid=id_en=1. After the last bit go to DATA, or go straight to CRC if the clamped DLC is 0.
- DATA: 8*DLC cycles; bit_valid=data_en=1. Byte order is 0..DLC-1.
- CRC: on entry, latch crc_out. Then CRC_W cycles; bit_valid=crc_en=1, CRC sent MSB first.
- DONE: one cycle with done=1 and busy=1, then IDLE.
- Outputs are registered. Cycle 0 is the accept edge, and field bit k is presented in cycle k+1 so downstream samples it on the next posedge.
- Frame timing for a DLC of n: ID in cycles 1..11, data in 12..11+8n, CRC in the next 15 cycles, done 1 cycle later.
- A request presented during DONE is not accepted; the earliest next accept is the cycle after done.
- CRC update per ID/data bit b: nxt = b ^ crc[14]; crc = {crc[13:0],1'b0} ^ (nxt ? CRC_POLY : 0). Initial value is 0.
- The CRC field itself is not folded into the CRC.
- req_dlc values 9..15 are clamped to 8.
- Strobes are mutually exclusive, and at most one is high per cycle.

Optional Feature:
Macro CAN_BIT_STUFF_EN.
- Defined: after 5 consecutive identical bit_out values within ID/DATA/CRC, insert one complementary bit for one cycle.
  - During the stuff bit: bit_valid=1, stuff_flag=1, id_en=data_en=crc_en=0.
  - Field counters pause, and the stuff bit is excluded from the CRC.
  - The stuff bit starts a new run of length 1.
  - The run counter resets on accept, and no stuff bit follows the final CRC bit.
- Undefined: no insertion; stuff_flag is constant 0; timing is exactly as in Behaviour.

Decomposition:
- Shared package can_pkg holds:
  - state enum can_seq_state_t
  - constants CAN_ID_W, CAN_MAX_BYTES, CAN_CRC_W, CAN_CRC15_POLY
- One sub-module, can_crc15: a serial CRC register with clear, enable, bit input and crc output. It is instantiated once, with its enable driven only on ID/data field bits.

Test Plan:
1. id=0x7FF, dlc=3, data 10 02 01 -> id_en in cycles 1-11 with all bits 1; data_en in cycles 12-35 carrying 0x10,0x02,0x01 MSB first; crc_en in 36-50 matching the bench CRC-15 model; done at 51; req_ready back to 1 at 52.
2. id=0x123, dlc=0 -> data_en never asserts; CRC in cycles 12-26; done at 27; crc_out equals the model CRC of 11 bits 0x123.
3. dlc=15, data=64'h0123456789ABCDEF -> clamped to 8; 64 data_en cycles (12-75); done at 91.
4. rst low during cycle 20 of a DATA field -> all outputs drop to 0 immediately with req_ready=1; after release, a new id=0x001/dlc=1 frame is sequenced correctly.
5. req_valid held high with a changed req_id while busy -> no accept; the second frame is accepted the cycle after done and uses the new ID.
6. CAN_BIT_STUFF_EN, id=0x7FF, dlc=0 -> stuff 0 bits in cycles 6 and 12 with stuff_flag=1 and no id_en; id_en spans 13 cycles; crc_out matches the unstuffed model.
